// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular show-ahead FIFO of
// {inst, pc} with occupancy count, mispredict flush and global stall.
module inst_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned IDWidth      = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      rob_instqueue_rst_in,
  input  logic                      if_instqueue_en_in,
  input  logic [IDWidth-1:0]        if_instqueue_inst_in,
  input  logic [AddressWidth-1:0]   if_instqueue_pc_in,
  output logic                      instqueue_if_rdy_out,
  output logic                      instqueue_id_valid_out,
  output logic [IDWidth-1:0]        instqueue_id_inst_out,
  output logic [AddressWidth-1:0]   instqueue_id_pc_out,
  input  logic                      id_instqueue_rdy_in,
  output logic [$clog2(DEPTH):0]    instqueue_count_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [IDWidth-1:0]      inst_mem [DEPTH];
  logic [AddressWidth-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [PW:0]             count;
  logic                    push;
  logic                    pop;

  always_comb begin
    instqueue_if_rdy_out   = (count != FULL_CNT) && !rob_instqueue_rst_in;
    instqueue_id_valid_out = (count != '0);
    instqueue_id_inst_out  = inst_mem[head];
    instqueue_id_pc_out    = pc_mem[head];
    instqueue_count_out    = count;
    // if_rdy already excludes flush and full, so push never competes with them
    push = rdy_in && if_instqueue_en_in && instqueue_if_rdy_out;
    pop  = rdy_in && instqueue_id_valid_out && id_instqueue_rdy_in
           && !rob_instqueue_rst_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (rob_instqueue_rst_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; it is only read while valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= if_instqueue_inst_in;
      pc_mem[tail]   <= if_instqueue_pc_in;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected {inst, pc} entries are queued on
// accepted pushes and compared against the head whenever a pop happens.
module tb_inst_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          rdy_in;
  logic          rob_rst;
  logic          if_en;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic          if_rdy_out;
  logic          valid_out;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;
  logic          id_rdy;
  logic [CW-1:0] count_out;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_pop;
  logic        did_pop;
  logic        pre_valid;
  logic        pre_if_rdy;
  logic [31:0] pre_pc;
  logic [31:0] pre_inst;

  inst_queue #(.DEPTH(DEPTH), .IDWidth(32), .AddressWidth(32)) dut (
    .clk_in                 (clk_in),
    .rst_n_in               (rst_n_in),
    .rdy_in                 (rdy_in),
    .rob_instqueue_rst_in   (rob_rst),
    .if_instqueue_en_in     (if_en),
    .if_instqueue_inst_in   (if_inst),
    .if_instqueue_pc_in     (if_pc),
    .instqueue_if_rdy_out   (if_rdy_out),
    .instqueue_id_valid_out (valid_out),
    .instqueue_id_inst_out  (inst_out),
    .instqueue_id_pc_out    (pc_out),
    .id_instqueue_rdy_in    (id_rdy),
    .instqueue_count_out    (count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One clock: apply inputs after the falling edge, capture the pre-edge head,
  // advance the scoreboard as the edge should, then settle just after the edge.
  task automatic drive_cycle(input logic en, input logic [31:0] pc,
                             input logic pop_req, input logic rob,
                             input logic rdy);
    @(negedge clk_in);
    if_en = en; if_pc = pc; if_inst = inst_of(pc);
    id_rdy = pop_req; rob_rst = rob; rdy_in = rdy;
    #1;
    pre_valid = valid_out; pre_pc = pc_out; pre_inst = inst_out;
    pre_if_rdy = if_rdy_out;
    did_pop = 1'b0;
    if (rdy) begin
      if (rob) exp_q.delete();
      else begin
        logic m_push;
        m_push = en && (exp_q.size() < DEPTH);
        if (pop_req && exp_q.size() > 0) begin
          exp_pop = exp_q.pop_front();
          did_pop = 1'b1;
        end
        if (m_push) exp_q.push_back({inst_of(pc), pc});
      end
    end
    @(posedge clk_in);
    #1;
    if_en = 1'b0; id_rdy = 1'b0; rob_rst = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (valid_out !== 1'b0 || if_rdy_out !== 1'b1 || count_out !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b if_rdy=%b count=%0d, expected valid=0 if_rdy=1 count=0",
               valid_out, if_rdy_out, count_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_order();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== CW'(3)) begin
      n_bad++; $display("FAIL order_count: got %0d, expected 3", count_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (!did_pop || pre_valid !== 1'b1 || pre_pc !== exp_pop[31:0]
          || pre_inst !== exp_pop[63:32] || pre_pc !== 32'(i * 4)) begin
        n_bad++;
        $display("FAIL order_pop[%0d]: got valid=%b pc=%h inst=%h, expected pc=%h inst=%h",
                 i, pre_valid, pre_pc, pre_inst, exp_pop[31:0], exp_pop[63:32]);
      end
    end
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_bad++; $display("FAIL order_empty_valid: got %b, expected 0", valid_out);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== '0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL underflow: got count=%0d valid=%b, expected count=0 valid=0", count_out, valid_out);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== CW'(16) || if_rdy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL full_state: got count=%0d if_rdy=%b, expected count=16 if_rdy=0", count_out, if_rdy_out);
    end
    drive_cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== CW'(16)) begin
      n_bad++; $display("FAIL full_drop: got count=%0d, expected 16", count_out);
    end
    // First pop offers 0x40 again: refused because the queue was full pre-edge.
    for (int i = 0; i < 16; i++) begin
      drive_cycle(i == 0, 32'h40, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (!did_pop || pre_pc !== exp_pop[31:0] || pre_inst !== exp_pop[63:32]
          || pre_pc !== 32'(i * 4)) begin
        n_bad++;
        $display("FAIL full_pop[%0d]: got pc=%h inst=%h, expected pc=%h inst=%h",
                 i, pre_pc, pre_inst, exp_pop[31:0], exp_pop[63:32]);
      end
    end
    n_vec++;
    if (count_out !== '0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL full_drain: got count=%0d valid=%b, expected count=0 valid=0", count_out, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 32'h114 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (!did_pop || pre_pc !== exp_pop[31:0] || pre_inst !== exp_pop[63:32]
          || count_out !== CW'(5)) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got pc=%h inst=%h count=%0d, expected pc=%h inst=%h count=5",
                 i, pre_pc, pre_inst, count_out, exp_pop[31:0], exp_pop[63:32]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (!did_pop || pre_pc !== exp_pop[31:0]) begin
        n_bad++; $display("FAIL b2b_drain[%0d]: got pc=%h, expected %h", i, pre_pc, exp_pop[31:0]);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 32'h800 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== CW'(7)) begin
      n_bad++; $display("FAIL flush_pre_count: got %0d, expected 7", count_out);
    end
    drive_cycle(1'b1, 32'hDEAD0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (pre_if_rdy !== 1'b0 || count_out !== '0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_state: got if_rdy=%b count=%0d valid=%b, expected if_rdy=0 count=0 valid=0",
               pre_if_rdy, count_out, valid_out);
    end
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (!did_pop || pre_pc !== exp_pop[31:0] || pre_pc !== 32'h200 || count_out !== '0) begin
      n_bad++;
      $display("FAIL flush_after: got pc=%h count=%0d, expected pc=00000200 count=0", pre_pc, count_out);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'hBAD0, 1'b1, i == 1, 1'b0);
      n_vec++;
      if (count_out !== CW'(4) || pc_out !== exp_q[0][31:0] || pc_out !== 32'h400) begin
        n_bad++;
        $display("FAIL stall[%0d]: got count=%0d pc=%h, expected count=4 pc=%h",
                 i, count_out, pc_out, exp_q[0][31:0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (!did_pop || pre_pc !== exp_pop[31:0] || pre_inst !== exp_pop[63:32]) begin
        n_bad++; $display("FAIL stall_drain[%0d]: got pc=%h, expected %h", i, pre_pc, exp_pop[31:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (count_out !== CW'(9)) begin
      n_bad++; $display("FAIL areset_pre_count: got %0d, expected 9", count_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if (valid_out !== 1'b0 || count_out !== '0 || if_rdy_out !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_state: got valid=%b count=%0d if_rdy=%b, expected valid=0 count=0 if_rdy=1",
               valid_out, count_out, if_rdy_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    drive_cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (!did_pop || pre_pc !== exp_pop[31:0] || pre_pc !== 32'h300 || count_out !== '0) begin
      n_bad++;
      $display("FAIL areset_after: got pc=%h count=%0d, expected pc=00000300 count=0", pre_pc, count_out);
    end
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_rst = 1'b0; if_en = 1'b0;
    if_inst = '0; if_pc = '0; id_rdy = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
